alu_core: RTL and testbench



---
 rtl/alu_core.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_alu_core.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// alu_core - registered 8-bit arithmetic/logic unit with split-operand capture.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-low
//   OPA, OPB   operands (WIDTH bits)
//   CMD        operation select (CMD_WIDTH bits)
//   INP_VALID  bit0 = OPA valid, bit1 = OPB valid
//   CE         clock enable; 0 freezes state, counter and outputs
//   CIN        carry in for ADD_CIN / SUB_CIN
//   MODE       1 = arithmetic, 0 = logical
//   RES        result (WIDTH+1 bits)
//   COUT       carry out
//   OFLOW      borrow / underflow
//   E, G, L    compare A==B, A>B, A<B
//   ERR        illegal command, illegal rotate amount, missing operand or timeout
//
// Optional build macro: ALU_MUL_EN enables arithmetic CMD 9 (MUL_INC) and
// CMD 10 (MUL_SHL) with a 3-cycle latency through MUL_BUSY.
//
// state    | meaning
// IDLE     | accept a new command
// WAIT_A   | OPB latched, waiting for OPA
// WAIT_B   | OPA latched, waiting for OPB
// MUL_BUSY | multiply in flight, inputs ignored (ALU_MUL_EN only)
module alu_core #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic [CMD_WIDTH-1:0] CMD,
  input  logic [1:0]           INP_VALID,
  input  logic                 CE,
  input  logic                 CIN,
  input  logic                 MODE,
  output logic [WIDTH:0]       RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 E,
  output logic                 G,
  output logic                 L,
  output logic                 ERR
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(TIMEOUT);
  localparam int OW  = WIDTH + 7;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_A   = 2'd1;
  localparam logic [1:0] WAIT_B   = 2'd2;
`ifdef ALU_MUL_EN
  localparam logic [1:0] MUL_BUSY = 2'd3;
`endif

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     lat_a_q, lat_a_d, lat_b_q, lat_b_d;
  logic [CMD_WIDTH-1:0] lat_cmd_q, lat_cmd_d;
  logic                 lat_mode_q, lat_mode_d, lat_cin_q, lat_cin_d;
  logic [OW-1:0]        out_q, out_d;

  logic [WIDTH-1:0]     s_a, s_b;
  logic [CMD_WIDTH-1:0] s_cmd;
  logic                 s_mode, s_cin;

  logic [WIDTH:0]       c_res, diff;
  logic [2*WIDTH-1:0]   rot2;
  logic                 c_cout, c_oflow, c_e, c_g, c_l, c_err;
  logic [1:0]           c_cls;   // operands needed, same bit order as INP_VALID; 00 = illegal
  logic                 done, ld_c, ld_err, arrive;
`ifdef ALU_MUL_EN
  logic                 c_mul, ld_mul;
  logic [WIDTH:0]       mul_q, mul_d;
`endif

  // In a wait state the latched operand and command replace the bus values.
  always_comb begin
    s_a    = OPA;
    s_b    = OPB;
    s_cmd  = CMD;
    s_mode = MODE;
    s_cin  = CIN;
    if (state_q == WAIT_A || state_q == WAIT_B) begin
      s_cmd  = lat_cmd_q;
      s_mode = lat_mode_q;
      s_cin  = lat_cin_q;
      if (state_q == WAIT_B) s_a = lat_a_q;
      else                   s_b = lat_b_q;
    end
  end

  always_comb begin
    c_res   = '0;
    c_cout  = 1'b0;
    c_oflow = 1'b0;
    c_e     = 1'b0;
    c_g     = 1'b0;
    c_l     = 1'b0;
    c_err   = 1'b0;
    c_cls   = 2'b00;
    diff    = '0;
    rot2    = '0;
`ifdef ALU_MUL_EN
    c_mul   = 1'b0;
`endif
    if (s_mode) begin
      case (s_cmd)
        4'd0: begin c_res = {1'b0, s_a} + {1'b0, s_b}; c_cout = c_res[WIDTH]; c_cls = 2'b11; end
        4'd1: begin
          diff = {1'b0, s_a} - {1'b0, s_b};
          c_res = {1'b0, diff[WIDTH-1:0]}; c_oflow = diff[WIDTH]; c_cls = 2'b11;
        end
        4'd2: begin
          c_res = {1'b0, s_a} + {1'b0, s_b} + {{WIDTH{1'b0}}, s_cin};
          c_cout = c_res[WIDTH]; c_cls = 2'b11;
        end
        4'd3: begin
          diff = {1'b0, s_a} - {1'b0, s_b} - {{WIDTH{1'b0}}, s_cin};
          c_res = {1'b0, diff[WIDTH-1:0]}; c_oflow = diff[WIDTH]; c_cls = 2'b11;
        end
        4'd4: begin c_res = {1'b0, s_a} + ONE; c_cout = c_res[WIDTH]; c_cls = 2'b01; end
        4'd5: begin
          diff = {1'b0, s_a} - ONE;
          c_res = {1'b0, diff[WIDTH-1:0]}; c_oflow = diff[WIDTH]; c_cls = 2'b01;
        end
        4'd6: begin c_res = {1'b0, s_b} + ONE; c_cout = c_res[WIDTH]; c_cls = 2'b10; end
        4'd7: begin
          diff = {1'b0, s_b} - ONE;
          c_res = {1'b0, diff[WIDTH-1:0]}; c_oflow = diff[WIDTH]; c_cls = 2'b10;
        end
        4'd8: begin c_e = (s_a == s_b); c_g = (s_a > s_b); c_l = (s_a < s_b); c_cls = 2'b11; end
`ifdef ALU_MUL_EN
        // Products wrap modulo 2^(WIDTH+1), i.e. truncation to RES width.
        4'd9:  begin c_res = ({1'b0, s_a} + ONE) * ({1'b0, s_b} + ONE); c_mul = 1'b1; c_cls = 2'b11; end
        4'd10: begin c_res = {s_a, 1'b0} * {1'b0, s_b}; c_mul = 1'b1; c_cls = 2'b11; end
`endif
        default: c_err = 1'b1;
      endcase
    end else begin
      case (s_cmd)
        4'd0:  begin c_res = {1'b0, s_a & s_b};    c_cls = 2'b11; end
        4'd1:  begin c_res = {1'b0, ~(s_a & s_b)}; c_cls = 2'b11; end
        4'd2:  begin c_res = {1'b0, s_a | s_b};    c_cls = 2'b11; end
        4'd3:  begin c_res = {1'b0, ~(s_a | s_b)}; c_cls = 2'b11; end
        4'd4:  begin c_res = {1'b0, s_a ^ s_b};    c_cls = 2'b11; end
        4'd5:  begin c_res = {1'b0, ~(s_a ^ s_b)}; c_cls = 2'b11; end
        4'd6:  begin c_res = {1'b0, ~s_a};         c_cls = 2'b01; end
        4'd7:  begin c_res = {1'b0, ~s_b};         c_cls = 2'b10; end
        4'd8:  begin c_res = {1'b0, s_a >> 1};     c_cls = 2'b01; end
        4'd9:  begin c_res = {1'b0, s_a << 1};     c_cls = 2'b01; end
        4'd10: begin c_res = {1'b0, s_b >> 1};     c_cls = 2'b10; end
        4'd11: begin c_res = {1'b0, s_b << 1};     c_cls = 2'b10; end
        // Rotate via a doubled operand so wrap-around bits fall out of a plain shift.
        4'd12, 4'd13: begin
          c_cls = 2'b11;
          if (|s_b[WIDTH-1:SHW]) begin
            c_err = 1'b1;
          end else if (s_cmd == 4'd12) begin
            rot2  = {s_a, s_a} << s_b[SHW-1:0];
            c_res = {1'b0, rot2[2*WIDTH-1:WIDTH]};
          end else begin
            rot2  = {s_a, s_a} >> s_b[SHW-1:0];
            c_res = {1'b0, rot2[WIDTH-1:0]};
          end
        end
        default: c_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lat_a_d    = lat_a_q;
    lat_b_d    = lat_b_q;
    lat_cmd_d  = lat_cmd_q;
    lat_mode_d = lat_mode_q;
    lat_cin_d  = lat_cin_q;
    done       = 1'b0;
    ld_c       = 1'b0;
    ld_err     = 1'b0;
    arrive     = (state_q == WAIT_B) ? INP_VALID[1] : INP_VALID[0];
`ifdef ALU_MUL_EN
    ld_mul     = 1'b0;
    mul_d      = mul_q;
`endif
    case (state_q)
      IDLE: begin
        if (INP_VALID != 2'b00) begin
          if (c_cls == 2'b00 || (INP_VALID & c_cls) == c_cls) begin
            done = 1'b1;
          end else if (c_cls == 2'b11) begin
            lat_a_d    = OPA;
            lat_b_d    = OPB;
            lat_cmd_d  = CMD;
            lat_mode_d = MODE;
            lat_cin_d  = CIN;
            cnt_d      = '0;
            state_d    = INP_VALID[0] ? WAIT_B : WAIT_A;
          end else begin
            ld_err = 1'b1;
          end
        end
      end
      WAIT_A, WAIT_B: begin
        if (arrive) begin
          done = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          ld_err  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef ALU_MUL_EN
      // Entered on the completion edge; the product leaves two edges later.
      MUL_BUSY: begin
        if (cnt_q == CW'(1)) begin
          ld_mul  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (done) begin
      cnt_d = '0;
`ifdef ALU_MUL_EN
      if (c_mul) begin
        state_d = MUL_BUSY;
        mul_d   = c_res;
      end else begin
        state_d = IDLE;
        ld_c    = 1'b1;
      end
`else
      state_d = IDLE;
      ld_c    = 1'b1;
`endif
    end

    out_d = out_q;
    if (ld_c)   out_d = {c_res, c_cout, c_oflow, c_e, c_g, c_l, c_err};
    if (ld_err) out_d = {{(OW-1){1'b0}}, 1'b1};
`ifdef ALU_MUL_EN
    if (ld_mul) out_d = {mul_q, 6'b0};
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lat_a_q    <= '0;
      lat_b_q    <= '0;
      lat_cmd_q  <= '0;
      lat_mode_q <= 1'b0;
      lat_cin_q  <= 1'b0;
      out_q      <= '0;
    end else if (CE) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lat_a_q    <= lat_a_d;
      lat_b_q    <= lat_b_d;
      lat_cmd_q  <= lat_cmd_d;
      lat_mode_q <= lat_mode_d;
      lat_cin_q  <= lat_cin_d;
      out_q      <= out_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)    mul_q <= '0;
    else if (CE) mul_q <= mul_d;
  end
`endif

  assign {RES, COUT, OFLOW, E, G, L, ERR} = out_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;

  logic       CLK, RST, CE, CIN, MODE;
  logic [7:0] OPA, OPB;
  logic [3:0] CMD;
  logic [1:0] INP_VALID;
  logic [8:0] RES;
  logic       COUT, OFLOW, E, G, L, ERR;

  alu_core dut (
    .CLK(CLK), .RST(RST), .OPA(OPA), .OPB(OPB), .CMD(CMD),
    .INP_VALID(INP_VALID), .CE(CE), .CIN(CIN), .MODE(MODE),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .E(E), .G(G), .L(L), .ERR(ERR)
  );

  // flag order {COUT, OFLOW, E, G, L, ERR}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_COUT = 6'b100000;
  localparam logic [5:0] F_OFL  = 6'b010000;
  localparam logic [5:0] F_E    = 6'b001000;
  localparam logic [5:0] F_G    = 6'b000100;
  localparam logic [5:0] F_L    = 6'b000010;
  localparam logic [5:0] F_ERR  = 6'b000001;

  typedef struct {
    int          due;
    logic [14:0] val;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic expect_at(input int due, input logic [8:0] r, input logic [5:0] f, input string nm);
    exp_t x;
    x.due = due;
    x.val = {r, f};
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  task automatic nx(input logic [8:0] r, input logic [5:0] f, input string nm);
    expect_at(cyc + 1, r, f, nm);
  endtask

  task automatic op(input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                    input logic [1:0] iv, input logic ci, input logic ce_v);
    MODE = m; CMD = c; OPA = a; OPB = b; INP_VALID = iv; CIN = ci; CE = ce_v;
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compares whatever the DUT shows on the cycle each expectation is due.
  exp_t  cur;
  string cur_nm;
  always @(negedge CLK) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      cur    = exp_q.pop_front();
      cur_nm = name_q.pop_front();
      checks++;
      if (cur.due != cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", cur_nm, cur.due, cyc);
      end else if ({RES, COUT, OFLOW, E, G, L, ERR} !== cur.val) begin
        failures++;
        $display("FAIL %s: got RES=%h flags(cout,oflow,e,g,l,err)=%b, expected RES=%h flags=%b",
                 cur_nm, RES, {COUT, OFLOW, E, G, L, ERR}, cur.val[14:6], cur.val[5:0]);
      end
    end
  end

  task automatic check_zero(input string nm);
    checks++;
    if ({RES, COUT, OFLOW, E, G, L, ERR} !== 15'd0) begin
      failures++;
      $display("FAIL %s: got outputs %h, expected all zero", nm, {RES, COUT, OFLOW, E, G, L, ERR});
    end
  endtask

  initial begin
    RST = 1'b1; CE = 1'b0; CIN = 1'b0; MODE = 1'b0; OPA = '0; OPB = '0; CMD = '0; INP_VALID = '0;
    #2 RST = 1'b0;
    #1 check_zero("reset_init");
    @(posedge CLK); #1;
    RST = 1'b1;

    // arithmetic
    nx(9'h100, F_COUT, "add_carry");    op(1, 4'd0, 8'hFF, 8'h01, 2'b11, 0, 1);
    nx(9'h000, F_L,    "cmp_lt");       op(1, 4'd8, 8'h05, 8'h09, 2'b11, 0, 1);
    nx(9'h0FF, F_OFL,  "sub_borrow");   op(1, 4'd1, 8'h03, 8'h04, 2'b11, 0, 1);
    nx(9'h031, F_NONE, "add_cin");      op(1, 4'd2, 8'h10, 8'h20, 2'b11, 1, 1);
    nx(9'h001, F_NONE, "sub_cin");      op(1, 4'd3, 8'h05, 8'h03, 2'b11, 1, 1);
    nx(9'h100, F_COUT, "inc_a");        op(1, 4'd4, 8'hFF, 8'h77, 2'b01, 0, 1);
    nx(9'h0FF, F_OFL,  "dec_a_zero");   op(1, 4'd5, 8'h00, 8'h00, 2'b01, 0, 1);
    nx(9'h0FF, F_NONE, "inc_b");        op(1, 4'd6, 8'h00, 8'hFE, 2'b10, 0, 1);
    nx(9'h00F, F_NONE, "dec_b");        op(1, 4'd7, 8'h00, 8'h10, 2'b10, 0, 1);
    nx(9'h000, F_E,    "cmp_eq");       op(1, 4'd8, 8'h07, 8'h07, 2'b11, 0, 1);
    nx(9'h000, F_G,    "cmp_gt");       op(1, 4'd8, 8'h09, 8'h05, 2'b11, 0, 1);

    // logical
    nx(9'h030, F_NONE, "and");          op(0, 4'd0, 8'hF0, 8'h3C, 2'b11, 0, 1);
    nx(9'h0CF, F_NONE, "nand");         op(0, 4'd1, 8'hF0, 8'h3C, 2'b11, 0, 1);
    nx(9'h0FC, F_NONE, "or");           op(0, 4'd2, 8'hF0, 8'h3C, 2'b11, 0, 1);
    nx(9'h003, F_NONE, "nor");          op(0, 4'd3, 8'hF0, 8'h3C, 2'b11, 0, 1);
    nx(9'h033, F_NONE, "xnor");         op(0, 4'd5, 8'hF0, 8'h3C, 2'b11, 0, 1);
    nx(9'h0F0, F_NONE, "not_b");        op(0, 4'd7, 8'h00, 8'h0F, 2'b10, 0, 1);
    nx(9'h002, F_NONE, "shl1_a");       op(0, 4'd9, 8'h81, 8'h00, 2'b01, 0, 1);
    nx(9'h040, F_NONE, "shr1_b");       op(0, 4'd10, 8'h00, 8'h81, 2'b10, 0, 1);
    nx(9'h003, F_NONE, "rol_1");        op(0, 4'd12, 8'h81, 8'h01, 2'b11, 0, 1);
    nx(9'h0C0, F_NONE, "ror_1");        op(0, 4'd13, 8'h81, 8'h01, 2'b11, 0, 1);
    nx(9'h0C0, F_NONE, "rol_7");        op(0, 4'd12, 8'h81, 8'h07, 2'b11, 0, 1);
    nx(9'h000, F_ERR,  "rol_bad_amt");  op(0, 4'd12, 8'h81, 8'h10, 2'b11, 0, 1);
    nx(9'h002, F_NONE, "add_small");    op(1, 4'd0, 8'h01, 8'h01, 2'b11, 0, 1);
    nx(9'h000, F_ERR,  "logic_cmd14");  op(0, 4'd14, 8'h12, 8'h34, 2'b11, 0, 1);
    nx(9'h002, F_NONE, "add_small2");   op(1, 4'd0, 8'h01, 8'h01, 2'b11, 0, 1);

    // CMD 9 arithmetic: multiply when enabled, illegal otherwise
`ifdef ALU_MUL_EN
    expect_at(cyc + 1, 9'h002, F_NONE, "mul_busy_hold1");
    expect_at(cyc + 2, 9'h002, F_NONE, "mul_busy_hold2");
    expect_at(cyc + 3, 9'h00C, F_NONE, "mul_inc");
    op(1, 4'd9, 8'h02, 8'h03, 2'b11, 0, 1);
    op(1, 4'd0, 8'hFF, 8'h01, 2'b11, 0, 1);
    op(0, 4'd4, 8'hAA, 8'h55, 2'b11, 0, 1);
`else
    nx(9'h000, F_ERR, "mul_disabled");  op(1, 4'd9, 8'h02, 8'h03, 2'b11, 0, 1);
`endif

    nx(9'h002, F_NONE, "add_small3");   op(1, 4'd0, 8'h01, 8'h01, 2'b11, 0, 1);
    nx(9'h000, F_ERR,  "inc_a_missing"); op(1, 4'd4, 8'h00, 8'h05, 2'b10, 0, 1);
    nx(9'h003, F_NONE, "add_1_2");      op(1, 4'd0, 8'h01, 8'h02, 2'b11, 0, 1);
    nx(9'h000, F_ERR,  "arith_cmd11");  op(1, 4'd11, 8'h01, 8'h02, 2'b11, 0, 1);
    nx(9'h003, F_NONE, "add_1_2b");     op(1, 4'd0, 8'h01, 8'h02, 2'b11, 0, 1);
    nx(9'h003, F_NONE, "ce_low_hold");  op(1, 4'd0, 8'hFF, 8'h01, 2'b11, 0, 0);

    // split operands: A first, B three cycles later, bus command ignored meanwhile
    nx(9'h003, F_NONE, "split_latch");  op(0, 4'd4, 8'hF0, 8'h00, 2'b01, 0, 1);
    nx(9'h003, F_NONE, "split_wait1");  op(0, 4'd4, 8'h00, 8'h00, 2'b00, 0, 1);
    nx(9'h003, F_NONE, "split_resend"); op(0, 4'd4, 8'h00, 8'h00, 2'b01, 0, 1);
    nx(9'h0CC, F_NONE, "split_xor");    op(1, 4'd0, 8'h00, 8'h3C, 2'b10, 0, 1);

    // timeout after 16 waiting cycles
    op(0, 4'd4, 8'hF0, 8'h00, 2'b01, 0, 1);
    for (int w = 1; w <= 16; w++) begin
      if (w == 15) nx(9'h0CC, F_NONE, "timeout_early");
      if (w == 16) nx(9'h000, F_ERR, "timeout");
      op(0, 4'd4, 8'h00, 8'h00, 2'b00, 0, 1);
    end

    // CE low for 5 waiting cycles stretches the timeout; an arrival while frozen is ignored
    nx(9'h002, F_NONE, "add_pre_ce");   op(1, 4'd0, 8'h01, 8'h01, 2'b11, 0, 1);
    op(0, 4'd4, 8'hF0, 8'h00, 2'b01, 0, 1);
    for (int w = 1; w <= 21; w++) begin
      if (w == 16) nx(9'h002, F_NONE, "ce_freeze_hold");
      if (w == 20) nx(9'h002, F_NONE, "ce_wait_hold");
      if (w == 21) nx(9'h000, F_ERR, "ce_timeout");
      op(0, 4'd4, 8'h00, 8'h3C, (w == 6) ? 2'b10 : 2'b00, 0, (w >= 4 && w <= 8) ? 1'b0 : 1'b1);
    end

    // asynchronous reset in the middle of a wait
    nx(9'h100, F_COUT, "add_pre_rst");  op(1, 4'd0, 8'hFF, 8'h01, 2'b11, 0, 1);
    nx(9'h100, F_COUT, "latch_pre_rst"); op(0, 4'd4, 8'hF0, 8'h00, 2'b01, 0, 1);
    op(0, 4'd4, 8'h00, 8'h00, 2'b00, 0, 1);
    #3 RST = 1'b0;
    #1 check_zero("async_reset");
    @(posedge CLK); #1;
    RST = 1'b1;
    nx(9'h000, F_NONE, "rst_fsm_idle"); op(0, 4'd4, 8'h00, 8'h3C, 2'b10, 0, 1);
    nx(9'h033, F_NONE, "post_rst_xor"); op(0, 4'd4, 8'h0F, 8'h00, 2'b01, 0, 1);

    op(0, 4'd0, 8'h00, 8'h00, 2'b00, 0, 1);
    op(0, 4'd0, 8'h00, 8'h00, 2'b00, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
